dmem_check_responder: RTL

DMEM_CHECK_RESPONDER -- requirements
Module: dmem_check_responder

---
 rtl/dmem_check_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_check_responder.sv
// dmem_check_responder
// Word-addressed data RAM for a processor test harness that also watches
// every store to reach a pass/fail verdict. A store of PASS_DATA to PASS_ADR
// passes, any other store to PASS_ADR fails, stores to IGNORE_ADR are
// tolerated, and a store anywhere else fails.
// Optional feature: define DMEM_TIMEOUT_EN to add a watchdog that fails the
// run after TIMEOUT cycles in RUN without a verdict.
module dmem_check_responder #(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] PASS_ADR   = 32'd100,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] IGNORE_ADR = 32'd96,
    parameter int          TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [15:0] store_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [15:0]   cycleCount_q;
    logic [15:0]   storeCount_q;
    logic [29:0]   wordIdx;
    logic          inRange;
    logic [AW-1:0] memIdx;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [15:0] WATCH_LAST = 16'(TIMEOUT - 1);

    logic timeout_q;
    logic timeout_d;
    logic verdictStore;
`endif

    assign wordIdx = DataAdr[31:2];
    assign inRange = (wordIdx < 30'(DEPTH));
    assign memIdx  = wordIdx[AW-1:0];

    // Load path: unregistered so a load sees a store from the previous cycle
    always_comb begin
        ReadData = 32'd0;
        if (inRange) begin
            ReadData = mem_q[memIdx];
        end
    end

    // RAM write port: stays live in every state and during reset
    always_ff @(posedge clk) begin
        if (MemWrite && inRange) begin
            mem_q[memIdx] <= WriteData;
        end
    end

    // Verdict state register (and watchdog flag when enabled)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
`ifdef DMEM_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef DMEM_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state decision from the store seen while running
    always_comb begin
        state_d = state_q;
`ifdef DMEM_TIMEOUT_EN
        timeout_d    = timeout_q;
        verdictStore = MemWrite && (DataAdr != IGNORE_ADR);
`endif
        if (state_q == RUN && MemWrite) begin
            if (DataAdr == PASS_ADR) begin
                state_d = (WriteData == PASS_DATA) ? PASS : FAIL;
            end else if (DataAdr != IGNORE_ADR) begin
                state_d = FAIL;
            end
        end
`ifdef DMEM_TIMEOUT_EN
        if (state_q == RUN && !verdictStore && cycleCount_q == WATCH_LAST) begin
            state_d   = FAIL;
            timeout_d = 1'b1;
        end
`endif
    end

    // Saturating run-time and store counters, frozen once a verdict exists
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount_q <= 16'd0;
            storeCount_q <= 16'd0;
        end else if (state_q == RUN) begin
            if (cycleCount_q != 16'hFFFF) begin
                cycleCount_q <= cycleCount_q + 16'd1;
            end
            if (MemWrite && storeCount_q != 16'hFFFF) begin
                storeCount_q <= storeCount_q + 16'd1;
            end
        end
    end

    // Status outputs decoded from the verdict state
    always_comb begin
        done        = (state_q != RUN);
        pass        = (state_q == PASS);
        cycle_count = cycleCount_q;
        store_count = storeCount_q;
`ifdef DMEM_TIMEOUT_EN
        timeout     = timeout_q;
`else
        timeout     = 1'b0;
`endif
    end

endmodule
